// File: rtl/pe_sched_pkg.sv
// Shared widths, fixed-point scaling and FSM state encoding for the pe_sched window scheduler.
package pe_sched_pkg;

  localparam int BIT_W    = 8;
  localparam int WIN_W    = 144;
  localparam int RES_W    = 16;
  localparam int PROD_LSB = 4;
  localparam int N_TAPS   = WIN_W / BIT_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CALC,
    S_OUT,
    S_DONE
  } state_t;

endpackage

// File: rtl/pe_sched_pe.sv
// Combinational 18-tap signed MAC: Q4.4 x Q4.4 products rescaled to Q4.4, summed, and rescaled again.
module pe
  import pe_sched_pkg::*;
(
  input  logic [WIN_W-1:0] win,
  input  logic [WIN_W-1:0] kern,
  output logic [RES_W-1:0] res
);

  logic signed [BIT_W-1:0]   a;
  logic signed [BIT_W-1:0]   b;
  logic signed [2*BIT_W-1:0] prod;
  logic signed [RES_W-1:0]   acc;

  // The accumulated sum goes through the same [11:4] window as each product before sign extension.
  always_comb begin
    a    = '0;
    b    = '0;
    prod = '0;
    acc  = '0;
    for (int k = 0; k < N_TAPS; k++) begin
      a    = win[k*BIT_W +: BIT_W];
      b    = kern[k*BIT_W +: BIT_W];
      prod = (2*BIT_W)'(a) * (2*BIT_W)'(b);
      acc  = acc + RES_W'(signed'(BIT_W'(prod >>> PROD_LSB)));
    end
    res = RES_W'(signed'(BIT_W'(acc >>> PROD_LSB)));
  end

endmodule

// File: rtl/pe_sched.sv
// Raster-order 3x3x2 window scheduler feeding one PE; optional ReLU clamp via PE_SCHED_RELU_EN.
//
// state  | meaning
// IDLE   | waiting for i_start; kernel latched on accept
// REQ    | o_win_req high for current row/col until i_win_vld
// CALC   | PE result registered into o_res_data
// OUT    | o_res_vld high until i_res_rdy; then advance col/row
// DONE   | one-cycle o_done pulse, back to IDLE
module pe_sched
  import pe_sched_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIN_W-1:0] i_kernal,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_win_req,
  output logic [7:0]       o_win_row,
  output logic [7:0]       o_win_col,
  input  logic             i_win_vld,
  input  logic [WIN_W-1:0] i_win_data,
  output logic             o_res_vld,
  input  logic             i_res_rdy,
  output logic [RES_W-1:0] o_res_data
);

  localparam logic [7:0] COL_LAST = 8'(IMG_W - 3);
  localparam logic [7:0] ROW_LAST = 8'(IMG_H - 3);

  state_t           state;
  logic [WIN_W-1:0] kern_q;
  logic [WIN_W-1:0] win_q;
  logic [7:0]       row_q;
  logic [7:0]       col_q;
  logic [RES_W-1:0] pe_res;
  logic [RES_W-1:0] res_out;

  pe u_pe (
    .win  (win_q),
    .kern (kern_q),
    .res  (pe_res)
  );

`ifdef PE_SCHED_RELU_EN
  assign res_out = pe_res[RES_W-1] ? '0 : pe_res;
`else
  assign res_out = pe_res;
`endif

  assign o_win_row = row_q;
  assign o_win_col = col_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      kern_q     <= '0;
      win_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_win_req  <= 1'b0;
      o_res_vld  <= 1'b0;
      o_res_data <= '0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_start) begin
            kern_q    <= i_kernal;
            row_q     <= '0;
            col_q     <= '0;
            o_busy    <= 1'b1;
            o_win_req <= 1'b1;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_win_vld) begin
            win_q     <= i_win_data;
            o_win_req <= 1'b0;
            state     <= S_CALC;
          end
        end
        S_CALC: begin
          o_res_data <= res_out;
          o_res_vld  <= 1'b1;
          state      <= S_OUT;
        end
        S_OUT: begin
          if (i_res_rdy) begin
            o_res_vld <= 1'b0;
            if (col_q == COL_LAST) begin
              col_q <= '0;
              if (row_q == ROW_LAST) begin
                row_q  <= '0;
                o_done <= 1'b1;
                state  <= S_DONE;
              end else begin
                row_q     <= row_q + 8'd1;
                o_win_req <= 1'b1;
                state     <= S_REQ;
              end
            end else begin
              col_q     <= col_q + 8'd1;
              o_win_req <= 1'b1;
              state     <= S_REQ;
            end
          end
        end
        S_DONE: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_sched.sv
// Scoreboard bench for pe_sched: a 4x4 and a 5x3 instance share stimulus, sel picks the active one.
module tb_pe_sched;
  import pe_sched_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, win_vld, res_rdy, sel;
  logic             start_a, start_b;
  logic [WIN_W-1:0] kernal, win_data;

  logic busy_a, done_a, req_a, vld_a, busy_b, done_b, req_b, vld_b;
  logic [7:0]  row_a, col_a, row_b, col_b;
  logic [15:0] data_a, data_b;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  pe_sched #(.IMG_W(4), .IMG_H(4)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_kernal(kernal),
    .o_busy(busy_a), .o_done(done_a), .o_win_req(req_a),
    .o_win_row(row_a), .o_win_col(col_a),
    .i_win_vld(win_vld), .i_win_data(win_data),
    .o_res_vld(vld_a), .i_res_rdy(res_rdy), .o_res_data(data_a)
  );

  pe_sched #(.IMG_W(5), .IMG_H(3)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_kernal(kernal),
    .o_busy(busy_b), .o_done(done_b), .o_win_req(req_b),
    .o_win_row(row_b), .o_win_col(col_b),
    .i_win_vld(win_vld), .i_win_data(win_data),
    .o_res_vld(vld_b), .i_res_rdy(res_rdy), .o_res_data(data_b)
  );

  logic        m_busy, m_done, m_req, m_vld;
  logic [7:0]  m_row, m_col;
  logic [15:0] m_data;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_done = sel ? done_b : done_a;
  assign m_req  = sel ? req_b  : req_a;
  assign m_vld  = sel ? vld_b  : vld_a;
  assign m_row  = sel ? row_b  : row_a;
  assign m_col  = sel ? col_b  : col_a;
  assign m_data = sel ? data_b : data_a;

`ifdef PE_SCHED_RELU_EN
  localparam logic [15:0] EXP_NEG = 16'h0000;
`else
  localparam logic [15:0] EXP_NEG = 16'hFFEE;
`endif

  typedef struct {
    int          row;
    int          col;
    logic [15:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_results, busy_cycles, done_cycles;
  bit          overlap;
  int          exp_row, exp_col, wcnt, fix_delay;
  bit          alt, tog;
  logic [7:0]  fill_tbl[0:2];
  logic [15:0] exp_tbl[0:2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // window responder: issues each window after the programmed delay and queues its expected result
  always @(negedge clk) begin
    if (m_req) begin
      if (wcnt >= (alt ? (tog ? 5 : 0) : fix_delay)) begin
        if (!win_vld) begin
          check("win_row", 32'(m_row), 32'(exp_row));
          check("win_col", 32'(m_col), 32'(exp_col));
          win_data = {18{fill_tbl[exp_col]}};
          exp_q.push_back('{row: exp_row, col: exp_col, data: exp_tbl[exp_col]});
          tog = ~tog;
          exp_col++;
          if (exp_col == (sel ? 3 : 2)) begin
            exp_col = 0;
            exp_row++;
          end
        end
        win_vld = 1'b1;
      end else begin
        wcnt++;
      end
    end else begin
      win_vld = 1'b0;
      wcnt    = 0;
    end
  end

  // result monitor
  always @(negedge clk) begin
    exp_t e;
    if (m_busy) busy_cycles++;
    if (m_done) done_cycles++;
    if (m_req && m_vld) overlap = 1'b1;
    if (m_vld && res_rdy) begin
      n_results++;
      check("result_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("res_data", 32'(m_data), 32'(e.data));
        check("res_row", 32'(m_row), 32'(e.row));
        check("res_col", 32'(m_col), 32'(e.col));
      end
    end
  end

  task automatic set_tbl(input logic [7:0] b, input logic [15:0] e);
    fill_tbl = '{b, b, b};
    exp_tbl  = '{e, e, e};
  endtask

  task automatic start_frame(input logic s, input logic [7:0] kb);
    @(posedge clk); #1;
    sel         = s;
    kernal      = {18{kb}};
    n_results   = 0;
    busy_cycles = 0;
    done_cycles = 0;
    overlap     = 1'b0;
    exp_row     = 0;
    exp_col     = 0;
    tog         = 1'b0;
    exp_q.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!m_busy) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_idle"}, 32'(ok), 32'd1);
  endtask

  task automatic end_frame(input string name, input int n_exp, input int busy_exp);
    check({name, "_results"}, 32'(n_results), 32'(n_exp));
    check({name, "_done_pulses"}, 32'(done_cycles), 32'd1);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check({name, "_req_vld_overlap"}, 32'(overlap), 32'd0);
    if (busy_exp >= 0) check({name, "_busy_cycles"}, 32'(busy_cycles), 32'(busy_exp));
  endtask

  initial begin
    bit seen;
    rst = 1'b1; start = 1'b0; win_vld = 1'b0; res_rdy = 1'b1; sel = 1'b0;
    kernal = '0; win_data = '0; fix_delay = 0; alt = 1'b0; tog = 1'b0; wcnt = 0;
    n_results = 0; busy_cycles = 0; done_cycles = 0; overlap = 1'b0;
    exp_row = 0; exp_col = 0;
    set_tbl(8'h00, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_done", 32'(done_a), 32'd0);
    check("rst_req", 32'(req_a), 32'd0);
    check("rst_vld", 32'(vld_a), 32'd0);
    check("rst_data", 32'(data_a), 32'd0);
    check("rst_row", 32'(row_a), 32'd0);
    check("rst_col", 32'(col_a), 32'd0);
    check("rst_b_busy", 32'(busy_b), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 4x4, all bytes 0x10: four results of 0x0012, 3 cycles per window
    set_tbl(8'h10, 16'h0012);
    start_frame(1'b0, 8'h10);
    wait_idle("t1");
    end_frame("t1", 4, 13);

    // 5x3, window delays 0/5 alternating, data varies by column
    fill_tbl = '{8'h10, 8'h20, 8'h30};
    exp_tbl  = '{16'h0012, 16'h0024, 16'h0036};
    alt = 1'b1;
    start_frame(1'b1, 8'h10);
    wait_idle("t2");
    end_frame("t2", 3, 15);
    alt = 1'b0;

    // negative products
    set_tbl(8'hF0, EXP_NEG);
    start_frame(1'b0, 8'h10);
    wait_idle("t3");
    end_frame("t3", 4, 13);

    // downstream stall of 10 cycles on the first result
    set_tbl(8'h30, 16'h006C);
    @(posedge clk); #1;
    res_rdy = 1'b0;
    start_frame(1'b0, 8'h20);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (m_vld) begin
        seen = 1'b1;
        break;
      end
    end
    check("t5_vld_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_stall_data", 32'(m_data), 32'h006C);
      check("t5_stall_vld", 32'(m_vld), 32'd1);
      check("t5_stall_req", 32'(m_req), 32'd0);
    end
    @(posedge clk); #1;
    res_rdy = 1'b1;
    wait_idle("t5");
    end_frame("t5", 4, -1);

    // reset during the second window request
    fix_delay = 5;
    set_tbl(8'h10, 16'h0012);
    start_frame(1'b0, 8'h10);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (n_results == 1 && m_req) begin
        seen = 1'b1;
        break;
      end
    end
    check("t6_second_req", 32'(seen), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_busy", 32'(m_busy), 32'd0);
    check("t6_done", 32'(m_done), 32'd0);
    check("t6_req", 32'(m_req), 32'd0);
    check("t6_vld", 32'(m_vld), 32'd0);
    check("t6_data", 32'(m_data), 32'd0);
    check("t6_row", 32'(m_row), 32'd0);
    check("t6_col", 32'(m_col), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    fix_delay = 0;
    repeat (3) @(negedge clk);
    check("t6_no_done", 32'(done_cycles), 32'd0);
    check("t6_no_partial", 32'(n_results), 32'd1);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    // full frame after reset, kernel 0x20 x window 0x30
    set_tbl(8'h30, 16'h006C);
    start_frame(1'b0, 8'h20);
    wait_idle("t4");
    end_frame("t4", 4, 13);

    // second start with a different kernel mid-frame is ignored
    set_tbl(8'h10, 16'h0012);
    start_frame(1'b0, 8'h10);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (n_results == 2) begin
        seen = 1'b1;
        break;
      end
    end
    check("t7_two_results", 32'(seen), 32'd1);
    @(posedge clk); #1;
    kernal = {18{8'h20}};
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    wait_idle("t7");
    end_frame("t7", 4, 13);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
